// File: rtl/fcml_spi_pkg.sv
// Shared definitions for the FCML SPI command path: frame layout, register
// addresses and the commit/fault state encoding.
package fcml_spi_pkg;

  localparam int FRAME_W = 33;

  // Frame bit-field positions
  localparam int PAR_BIT       = 32;
  localparam int ADDR_HI       = 31;
  localparam int ADDR_LO       = 28;
  localparam int RSVD_HI       = 27;
  localparam int RSVD_LO       = 24;
  localparam int SEQ_HI        = 23;
  localparam int SEQ_LO        = 16;
  localparam int DATA_HI       = 15;
  localparam int DATA_LO       = 0;
  localparam int CLR_FAULT_BIT = 15;

  // Register addresses; anything above ADDR_COMMIT is illegal
  localparam logic [3:0] ADDR_DUTY_A = 4'd0;
  localparam logic [3:0] ADDR_DUTY_B = 4'd1;
  localparam logic [3:0] ADDR_DUTY_C = 4'd2;
  localparam logic [3:0] ADDR_CTRL   = 4'd3;
  localparam logic [3:0] ADDR_COMMIT = 4'd4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PEND  = 2'd1,
    FAULT = 2'd2
  } fcml_state_e;

  // A frame is good when the XOR over all 33 bits is 1 (odd parity)
  function automatic logic frame_parity_ok(input logic [FRAME_W-1:0] f);
    return ^f;
  endfunction

endpackage

// File: rtl/fcml_link_wdt.sv
// Link watchdog: counts clk cycles since the last kick, saturating at
// WDT_CYCLES-1; expire is high while the counter sits at that threshold.
module fcml_link_wdt #(
  parameter int WDT_CYCLES = 100000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic kick,
  output logic expire
);

  localparam int CW = (WDT_CYCLES > 2) ? $clog2(WDT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(WDT_CYCLES - 1);

  logic [CW-1:0] cnt;

  // Count idle cycles; a kick restarts from 0, otherwise hold at the threshold
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (kick) begin
      cnt <= '0;
    end else if (cnt != CNT_MAX) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expire = (cnt == CNT_MAX);

endmodule

// File: rtl/fcml_spi_cmd_ctrl.sv
// Command controller behind the SPI word receiver of the three-phase FCML
// modulator. Validates each received frame, writes shadow registers, and
// moves shadows to the active settings only at a carrier sync boundary.
// A link watchdog forces the PWM enables off when the host goes silent.
//
// Frame handshake: frame_valid is a one-cycle strobe with no back-pressure
// (there is no ready); frame_data is sampled on the same rising edge and
// every strobe is consumed, either accepted or counted as rejected.
module fcml_spi_cmd_ctrl
  import fcml_spi_pkg::*;
#(
  parameter int DUTY_W     = 16,
  parameter int WDT_CYCLES = 100000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [FRAME_W-1:0] frame_data,
  input  logic               frame_valid,
  input  logic               sync_pulse,
  output logic [DUTY_W-1:0]  duty_a,
  output logic [DUTY_W-1:0]  duty_b,
  output logic [DUTY_W-1:0]  duty_c,
  output logic [2:0]         pwm_en,
  output logic               fault,
  output logic               commit_pending,
  output logic [7:0]         last_seq,
  output logic [7:0]         err_cnt,
  output fcml_state_e        state_dbg
);

  // Frame fields
  logic [3:0]  f_addr;
  logic [3:0]  f_rsvd;
  logic [7:0]  f_seq;
  logic [15:0] f_data;

  assign f_addr = frame_data[ADDR_HI:ADDR_LO];
  assign f_rsvd = frame_data[RSVD_HI:RSVD_LO];
  assign f_seq  = frame_data[SEQ_HI:SEQ_LO];
  assign f_data = frame_data[DATA_HI:DATA_LO];

  logic frame_good;
  logic frame_bad;
  logic is_commit;
  logic is_clear;
  logic wdt_expire;

  // Frame check: parity, reserved field and address range
  always_comb begin
    frame_good = frame_valid && frame_parity_ok(frame_data) &&
                 (f_rsvd == 4'd0) && (f_addr <= ADDR_COMMIT);
    frame_bad  = frame_valid && !frame_good;
    is_commit  = frame_good && (f_addr == ADDR_COMMIT);
    is_clear   = frame_good && (f_addr == ADDR_CTRL) && f_data[CLR_FAULT_BIT];
  end

  fcml_link_wdt #(
    .WDT_CYCLES (WDT_CYCLES)
  ) u_wdt (
    .clk    (clk),
    .rst_n  (rst_n),
    .kick   (frame_good),
    .expire (wdt_expire)
  );

  logic [DUTY_W-1:0] shadow_a;
  logic [DUTY_W-1:0] shadow_b;
  logic [DUTY_W-1:0] shadow_c;
  logic [2:0]        en_shadow;

  // Shadow writes, sequence tag and reject counter; shadows accept writes in every state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shadow_a  <= '0;
      shadow_b  <= '0;
      shadow_c  <= '0;
      en_shadow <= '0;
      last_seq  <= '0;
      err_cnt   <= '0;
    end else begin
      if (frame_good) begin
        last_seq <= f_seq;
        case (f_addr)
          ADDR_DUTY_A: shadow_a  <= f_data[DUTY_W-1:0];
          ADDR_DUTY_B: shadow_b  <= f_data[DUTY_W-1:0];
          ADDR_DUTY_C: shadow_c  <= f_data[DUTY_W-1:0];
          ADDR_CTRL:   en_shadow <= f_data[2:0];
          default:     ;
        endcase
      end
      if (frame_bad && (err_cnt != 8'hFF)) begin
        err_cnt <= err_cnt + 8'd1;
      end
    end
  end

  fcml_state_e state;

  // Commit/fault FSM with registered active settings and status flags
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      fault          <= 1'b0;
      commit_pending <= 1'b0;
      pwm_en         <= '0;
      duty_a         <= '0;
      duty_b         <= '0;
      duty_c         <= '0;
    end else if ((state != FAULT) && wdt_expire && !frame_good) begin
      // Link lost: kill the enables, drop any pending commit, hold the duties
      state          <= FAULT;
      fault          <= 1'b1;
      commit_pending <= 1'b0;
      pwm_en         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (is_commit) begin
            state          <= PEND;
            commit_pending <= 1'b1;
          end
        end
        PEND: begin
          // Shadows as they stand before this edge are what get applied
          if (sync_pulse) begin
            state          <= IDLE;
            commit_pending <= 1'b0;
            duty_a         <= shadow_a;
            duty_b         <= shadow_b;
            duty_c         <= shadow_c;
            pwm_en         <= en_shadow;
          end
        end
        FAULT: begin
          // Enables stay off until a later commit completes
          if (is_clear) begin
            state <= IDLE;
            fault <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_fcml_spi_cmd_ctrl.sv
// Testbench for fcml_spi_cmd_ctrl: a table of single-edge vectors for the
// main write/commit path plus hand-written sequences for the saturating
// error counter, watchdog fault/recovery and reset during a pending commit.
module tb_fcml_spi_cmd_ctrl;
  import fcml_spi_pkg::*;

  localparam int DUTY_W = 16;
  localparam int WDT    = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [32:0]       frame_data = '0;
  logic              frame_valid = 1'b0;
  logic              sync_pulse = 1'b0;
  logic [DUTY_W-1:0] duty_a, duty_b, duty_c;
  logic [2:0]        pwm_en;
  logic              fault, commit_pending;
  logic [7:0]        last_seq, err_cnt;
  fcml_state_e       state_dbg;

  int n_cmp = 0;
  int n_err = 0;

  fcml_spi_cmd_ctrl #(
    .DUTY_W     (DUTY_W),
    .WDT_CYCLES (WDT)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .frame_data     (frame_data),
    .frame_valid    (frame_valid),
    .sync_pulse     (sync_pulse),
    .duty_a         (duty_a),
    .duty_b         (duty_b),
    .duty_c         (duty_c),
    .pwm_en         (pwm_en),
    .fault          (fault),
    .commit_pending (commit_pending),
    .last_seq       (last_seq),
    .err_cnt        (err_cnt),
    .state_dbg      (state_dbg)
  );

  // Clock
  always #5 clk = ~clk;

  // Build a frame with correct odd parity
  function automatic logic [32:0] mk(input logic [3:0] addr, input logic [7:0] seq,
                                     input logic [15:0] data, input logic [3:0] rsvd = 4'd0);
    logic [31:0] body;
    body = {addr, rsvd, seq, data};
    return {~(^body), body};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One rising edge; outputs are sampled 1 ns later
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Apply one edge with the given frame/sync, then clear the strobes
  task automatic step(input logic [32:0] f, input logic v, input logic s);
    frame_data  = f;
    frame_valid = v;
    sync_pulse  = s;
    tick();
    frame_valid = 1'b0;
    sync_pulse  = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step('0, 1'b0, 1'b0);
    rst_n = 1'b1;
  endtask

  typedef struct {
    string       name;
    logic [32:0] frame;
    logic        valid;
    logic        sync;
    logic [15:0] exp_a;
    logic [15:0] exp_b;
    logic [15:0] exp_c;
    logic [2:0]  exp_en;
    logic        exp_pend;
    logic [7:0]  exp_seq;
    logic [7:0]  exp_err;
  } vec_t;

  vec_t vq[$];

  initial begin
    // ---------------- table-driven main path ----------------
    vq.push_back('{"wr_a",      mk(4'd0, 8'h01, 16'h1234),          1, 0, 16'h0,    16'h0,    16'h0,   3'd0, 0, 8'h01, 8'd0});
    vq.push_back('{"wr_b",      mk(4'd1, 8'h02, 16'h0456),          1, 0, 16'h0,    16'h0,    16'h0,   3'd0, 0, 8'h02, 8'd0});
    vq.push_back('{"wr_c",      mk(4'd2, 8'h03, 16'h0789),          1, 0, 16'h0,    16'h0,    16'h0,   3'd0, 0, 8'h03, 8'd0});
    vq.push_back('{"wr_ctrl",   mk(4'd3, 8'h04, 16'h0007),          1, 0, 16'h0,    16'h0,    16'h0,   3'd0, 0, 8'h04, 8'd0});
    vq.push_back('{"commit",    mk(4'd4, 8'h05, 16'h0000),          1, 0, 16'h0,    16'h0,    16'h0,   3'd0, 1, 8'h05, 8'd0});
    vq.push_back('{"wait",      33'd0,                              0, 0, 16'h0,    16'h0,    16'h0,   3'd0, 1, 8'h05, 8'd0});
    vq.push_back('{"sync",      33'd0,                              0, 1, 16'h1234, 16'h0456, 16'h0789, 3'd7, 0, 8'h05, 8'd0});
    vq.push_back('{"bad_par",   mk(4'd0, 8'h66, 16'hAAAA) ^ 33'd1,  1, 0, 16'h1234, 16'h0456, 16'h0789, 3'd7, 0, 8'h05, 8'd1});
    vq.push_back('{"bad_addr",  mk(4'd9, 8'h5A, 16'h0001),          1, 0, 16'h1234, 16'h0456, 16'h0789, 3'd7, 0, 8'h05, 8'd2});
    vq.push_back('{"bad_rsvd",  mk(4'd0, 8'h77, 16'h0BAD, 4'd2),    1, 0, 16'h1234, 16'h0456, 16'h0789, 3'd7, 0, 8'h05, 8'd3});
    vq.push_back('{"wr_a2",     mk(4'd0, 8'h06, 16'h1111),          1, 0, 16'h1234, 16'h0456, 16'h0789, 3'd7, 0, 8'h06, 8'd3});
    vq.push_back('{"cmt_sync",  mk(4'd4, 8'h07, 16'h0000),          1, 1, 16'h1234, 16'h0456, 16'h0789, 3'd7, 1, 8'h07, 8'd3});
    vq.push_back('{"wrb_sync",  mk(4'd1, 8'h08, 16'h2222),          1, 1, 16'h1111, 16'h0456, 16'h0789, 3'd7, 0, 8'h08, 8'd3});
    vq.push_back('{"commit2",   mk(4'd4, 8'h09, 16'h0000),          1, 0, 16'h1111, 16'h0456, 16'h0789, 3'd7, 1, 8'h09, 8'd3});
    vq.push_back('{"sync2",     33'd0,                              0, 1, 16'h1111, 16'h2222, 16'h0789, 3'd7, 0, 8'h09, 8'd3});

    #2;
    do_reset();
    chk("rst_duty_a", 32'(duty_a), 0);
    chk("rst_pwm_en", 32'(pwm_en), 0);
    chk("rst_fault",  32'(fault), 0);
    chk("rst_pend",   32'(commit_pending), 0);
    chk("rst_seq",    32'(last_seq), 0);
    chk("rst_err",    32'(err_cnt), 0);
    chk("rst_state",  32'(state_dbg), 32'(IDLE));

    foreach (vq[i]) begin
      step(vq[i].frame, vq[i].valid, vq[i].sync);
      chk({vq[i].name, ".duty_a"}, 32'(duty_a), 32'(vq[i].exp_a));
      chk({vq[i].name, ".duty_b"}, 32'(duty_b), 32'(vq[i].exp_b));
      chk({vq[i].name, ".duty_c"}, 32'(duty_c), 32'(vq[i].exp_c));
      chk({vq[i].name, ".pwm_en"}, 32'(pwm_en), 32'(vq[i].exp_en));
      chk({vq[i].name, ".pend"},   32'(commit_pending), 32'(vq[i].exp_pend));
      chk({vq[i].name, ".seq"},    32'(last_seq), 32'(vq[i].exp_seq));
      chk({vq[i].name, ".err"},    32'(err_cnt), 32'(vq[i].exp_err));
      chk({vq[i].name, ".fault"},  32'(fault), 0);
    end

    // ---------------- err_cnt saturation ----------------
    do_reset();
    step(mk(4'd0, 8'h11, 16'h5555) ^ 33'd1, 1'b1, 1'b0);
    chk("sat_first", 32'(err_cnt), 1);
    for (int i = 1; i < 300; i++) begin
      step(mk(4'd0, 8'h11, 16'h5555) ^ 33'd1, 1'b1, 1'b0);
      if (i == 254) chk("sat_255", 32'(err_cnt), 255);
    end
    chk("sat_hold",   32'(err_cnt), 255);
    chk("sat_seq",    32'(last_seq), 0);
    chk("sat_shadow", 32'(duty_a), 0);

    // ---------------- watchdog: good frame on threshold edge wins ----------------
    do_reset();
    for (int i = 0; i < WDT - 1; i++) step('0, 1'b0, 1'b0);
    chk("wdt_pre", 32'(fault), 0);
    step(mk(4'd0, 8'h21, 16'h0001), 1'b1, 1'b0);
    chk("wdt_kick_win", 32'(fault), 0);
    step('0, 1'b0, 1'b0);
    chk("wdt_kick_after", 32'(fault), 0);

    // ---------------- watchdog: fault with no frames after reset ----------------
    do_reset();
    for (int i = 0; i < WDT - 1; i++) step('0, 1'b0, 1'b0);
    chk("wdt_cyc15", 32'(fault), 0);
    step('0, 1'b0, 1'b0);
    chk("wdt_cyc16", 32'(fault), 1);
    chk("wdt_state", 32'(state_dbg), 32'(FAULT));

    // ---------------- watchdog: fault while enabled, then recovery ----------------
    do_reset();
    step(mk(4'd0, 8'h30, 16'h0ABC), 1'b1, 1'b0);
    step(mk(4'd3, 8'h31, 16'h0005), 1'b1, 1'b0);
    step(mk(4'd4, 8'h32, 16'h0000), 1'b1, 1'b0);
    step(mk(4'd0, 8'h33, 16'h0DEF), 1'b1, 1'b0); // shadow only; next commit would apply it
    step(mk(4'd4, 8'h34, 16'h0000), 1'b1, 1'b1); // commit in PEND plus sync: applies 0x0DEF
    chk("en_on",     32'(pwm_en), 5);
    chk("en_duty_a", 32'(duty_a), 32'h0DEF);
    step(mk(4'd4, 8'h35, 16'h0000), 1'b1, 1'b0); // last good frame
    chk("pend_before_fault", 32'(commit_pending), 1);
    for (int i = 0; i < WDT - 1; i++) step('0, 1'b0, 1'b0);
    chk("flt_not_yet", 32'(fault), 0);
    chk("flt_en_held", 32'(pwm_en), 5);
    step('0, 1'b0, 1'b0);
    chk("flt_set",     32'(fault), 1);
    chk("flt_en_off",  32'(pwm_en), 0);
    chk("flt_pend",    32'(commit_pending), 0);
    chk("flt_duty",    32'(duty_a), 32'h0DEF);
    step(mk(4'd4, 8'h36, 16'h0000), 1'b1, 1'b1); // commit and sync ignored in fault
    chk("flt_cmt_ign", 32'(commit_pending), 0);
    chk("flt_cmt_seq", 32'(last_seq), 32'h36);
    step(mk(4'd3, 8'h37, 16'h8005), 1'b1, 1'b0);
    chk("clr_fault",   32'(fault), 0);
    chk("clr_en",      32'(pwm_en), 0);
    chk("clr_state",   32'(state_dbg), 32'(IDLE));
    step(mk(4'd4, 8'h38, 16'h0000), 1'b1, 1'b0);
    step('0, 1'b0, 1'b1);
    chk("rec_en",      32'(pwm_en), 5);

    // ---------------- reset while commit is pending ----------------
    do_reset();
    step(mk(4'd0, 8'h40, 16'h4321), 1'b1, 1'b0);
    step(mk(4'd3, 8'h41, 16'h0007), 1'b1, 1'b0);
    step(mk(4'd4, 8'h42, 16'h0000), 1'b1, 1'b0);
    step('0, 1'b0, 1'b1);
    step(mk(4'd0, 8'h43, 16'h9999), 1'b1, 1'b0);
    step(mk(4'd4, 8'h44, 16'h0000), 1'b1, 1'b0);
    chk("pr_pend", 32'(commit_pending), 1);
    chk("pr_duty", 32'(duty_a), 32'h4321);
    rst_n = 1'b0;
    step(mk(4'd0, 8'h45, 16'h7777), 1'b1, 1'b0);
    rst_n = 1'b1;
    chk("rp_duty", 32'(duty_a), 0);
    chk("rp_en",   32'(pwm_en), 0);
    chk("rp_pend", 32'(commit_pending), 0);
    chk("rp_seq",  32'(last_seq), 0);
    step('0, 1'b0, 1'b1);
    chk("rp_sync_duty", 32'(duty_a), 0);
    chk("rp_sync_en",   32'(pwm_en), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fcml_spi_cmd_ctrl.md
# fcml_spi_cmd_ctrl

Command controller behind the 33-bit SPI word receiver of the three-phase FCML modulator. It takes each completed SPI word with its one-cycle valid strobe and checks parity and address. Valid writes go to per-phase duty shadow registers and a control shadow register. Shadow contents move to the active modulator settings only at a carrier-synchronous boundary, and a link watchdog forces the PWM outputs off if the host goes silent.

## Interface
Parameters:
- DUTY_W, 16: duty word width, 1..16; duty taken from frame[DUTY_W-1:0].
- WDT_CYCLES, 100000: clk cycles without a good frame before fault (1 ms at 100 MHz); ≥ 4.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- frame_data  in  33  received SPI word, stable while frame_valid=1.
- frame_valid  in  1  one-cycle strobe, one per received word.
- sync_pulse  in  1  one-cycle strobe at PWM carrier boundary.
- duty_a / duty_b / duty_c  out  DUTY_W each  active duty per phase.
- pwm_en  out  3  active per-phase enable.
- fault  out  1  watchdog fault latched.
- commit_pending  out  1  commit requested, waiting for sync_pulse.
- last_seq  out  8  sequence tag of last accepted frame.
- err_cnt  out  8  saturating count of rejected frames.

## Operation
Frame format:
- [32] parity bit; the frame is good if the XOR of all 33 bits is 1 (odd parity).
- [31:28] address.
- [27:24] reserved; must be 0.
- [23:16] sequence tag.
- [15:0] data.

Addresses:
- 0/1/2: write duty shadow A/B/C.
- 3: control. data[2:0] goes to the enable shadow. data[15]=1 clears fault.
- 4: commit request.
- 5..15: illegal.

Rejection:
- Bad parity, nonzero reserved bits or an illegal address reject the frame.
- A rejected frame makes no register change, increments err_cnt (saturates at 255) and does not feed the watchdog.
- Good frames update last_seq and reset the watchdog counter to 0.

FSM states IDLE, PEND and FAULT:
- IDLE → PEND on a good commit frame.
- PEND → IDLE on sync_pulse. On that edge, active duties and pwm_en load from the shadows.
- Shadow writes in PEND are allowed; the values present at the sync_pulse edge are what get copied.
- A commit frame received in PEND is accepted (tag and watchdog updated) with no other effect.
- Any state → FAULT when the watchdog counter reaches WDT_CYCLES-1. On entry, pwm_en is forced to 0 and the pending commit is dropped. Active duties are held.
- In FAULT, shadow writes are accepted. Commit frames and sync_pulse are ignored.
- FAULT → IDLE on a good control frame with data[15]=1. The enable shadow is also written by that frame, but pwm_en stays 0 until a later commit completes.

Reset values:
- All duties, shadows and pwm_en: 0.
- last_seq, err_cnt, watchdog counter: 0.
- fault=0, commit_pending=0, FSM in IDLE.

## Timing
- Frame processed on the clk edge where frame_valid=1; shadow, last_seq and err_cnt are visible the next cycle.
- commit_pending=1 from the cycle after the commit frame until the cycle after the applying sync_pulse.
- Commit latency: outputs change the cycle after the first sync_pulse that occurs strictly after the commit frame's edge.
- A commit frame and sync_pulse on the same edge in IDLE: enter PEND, no transfer; the next sync_pulse applies.
- Shadow write and sync_pulse on the same edge in PEND: the active register takes the old shadow value; the new value waits for the next commit.
- Watchdog: counter increments every cycle without a good frame and saturates. With no frames after reset, fault=1 on cycle WDT_CYCLES. A good frame on the threshold edge wins: no fault.
- fault and the pwm_en forcing take effect the same cycle as each other.
- rst_n=0 sampled on an edge forces all reset values next cycle, regardless of state or an in-flight frame.

## Structure
- Shared package fcml_spi_pkg holds:
  - FRAME_W=33.
  - Address constants ADDR_DUTY_A..ADDR_COMMIT.
  - The bit-field position constants.
  - The state enum {IDLE, PEND, FAULT}.
- One sub-module, fcml_link_wdt: counter with kick input, WDT_CYCLES parameter and expire output.
- Frame check (parity, reserved bits, address) is combinational in the top level.

## Test plan
- Write A=0x1234, B=0x0456, C=0x0789, control=0x0007, commit, then sync_pulse → duties and pwm_en=3'b111 change only the cycle after the sync_pulse; commit_pending 1→0.
- Frame with one flipped bit (bad parity) to address 0 → duty_a unchanged, err_cnt +1, last_seq unchanged. Repeat 300 times → err_cnt holds 255.
- Commit frame and sync_pulse on the same cycle → no transfer; the next sync_pulse transfers.
- WDT_CYCLES=16 with no frames → fault=1 at cycle 16 and pwm_en=0. Control frame 0x8005 → fault=0, pwm_en still 0; commit + sync → pwm_en=3'b101.
- rst_n low for one cycle while in PEND → all outputs 0 and commit_pending=0; a later sync_pulse has no effect.
- Address 9 with good parity and sequence tag 0x5A → err_cnt +1, last_seq unchanged, watchdog not reset.
